// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write register file with registered reads, optional write-to-read bypass,
// optional hardwired-zero register 0 and a per-register busy scoreboard.
module regfile_2r1w_sb #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rvalid,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy1,
    output logic              busy2
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic              r_rvalid;
    logic [DEPTH-1:0]  r_busy;

    logic              w_wr_ok;
    logic              w_rsv_ok;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [DATA_W-1:0] w_rval1;
    logic [DATA_W-1:0] w_rval2;

    // Address names a real register that accepts writes and reservations.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        logic in_rng;
        logic is_zero;
        in_rng  = ({1'b0, a} < DEPTH_C);
        is_zero = (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
        return in_rng && !is_zero;
    endfunction

    // Out-of-range and zero-register addresses read as zero; bypass takes same-edge write data.
    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] v;
        if (!addr_legal(a)) begin
            v = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && we && (waddr == a)) begin
            v = wdata;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Port legality, read data selection and scoreboard next state (set beats clear).
    always_comb begin
        w_wr_ok    = we && addr_legal(waddr);
        w_rsv_ok   = rsv_en && addr_legal(rsv_addr);
        w_rval1    = read_val(raddr1, r_mem[raddr1]);
        w_rval2    = read_val(raddr2, r_mem[raddr2]);
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[waddr] = 1'b0;
        end else begin
            w_busy_nxt = w_busy_nxt;
        end
        if (w_rsv_ok) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end else begin
            w_busy_nxt = w_busy_nxt;
        end
    end

    // Busy lookups are combinational so decode sees reservations without a cycle of lag.
    always_comb begin
        busy1 = addr_legal(raddr1) ? r_busy[raddr1] : 1'b0;
        busy2 = addr_legal(raddr2) ? r_busy[raddr2] : 1'b0;
    end

    // Register array storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end else begin
            r_mem[0] <= r_mem[0];
        end
    end

    // Registered read ports, valid strobe and scoreboard bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata1 <= {DATA_W{1'b0}};
            r_rdata2 <= {DATA_W{1'b0}};
            r_rvalid <= 1'b0;
            r_busy   <= {DEPTH{1'b0}};
        end else begin
            if (rd_en) begin
                r_rdata1 <= w_rval1;
                r_rdata2 <= w_rval2;
                r_rvalid <= 1'b1;
            end else begin
                r_rvalid <= 1'b0;
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign rdata1 = r_rdata1;
    assign rdata2 = r_rdata2;
    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Self-checking bench: two configurations (8-deep with bypass; 6-deep with zero register,
// no bypass) driven in lockstep and compared every cycle against an array-based model.
module tb_regfile_2r1w_sb;

    logic       clk;
    logic       rst;
    logic       rd_en;
    logic [2:0] raddr1;
    logic [2:0] raddr2;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       rsv_en;
    logic [2:0] rsv_addr;

    logic [7:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
    logic       a_rvalid, b_rvalid, a_busy1, a_busy2, b_busy1, b_busy2;

    int total = 0;
    int bad   = 0;

    regfile_2r1w_sb #(.DATA_W(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(a_rdata1), .rdata2(a_rdata2), .rvalid(a_rvalid),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy1(a_busy1), .busy2(a_busy2));

    regfile_2r1w_sb #(.DATA_W(8), .DEPTH(6), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(b_rdata1), .rdata2(b_rdata2), .rvalid(b_rvalid),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy1(b_busy1), .busy2(b_busy2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: index 0 = dut_a configuration, index 1 = dut_b configuration.
    int         cfg_depth [2] = '{8, 6};
    bit         cfg_zr    [2] = '{1'b0, 1'b1};
    bit         cfg_bp    [2] = '{1'b1, 1'b0};
    logic [7:0] m_reg  [2][8];
    bit         m_busy [2][8];
    logic [7:0] m_rd1  [2];
    logic [7:0] m_rd2  [2];
    bit         m_rv   [2];

    function automatic bit legal(int k, int a);
        return (a < cfg_depth[k]) && !(cfg_zr[k] && a == 0);
    endfunction

    function automatic logic [7:0] val(int k, int a);
        if (!legal(k, a)) return 8'h00;
        if (cfg_bp[k] && we && int'(waddr) == a) return wdata;
        return m_reg[k][a];
    endfunction

    function automatic logic [7:0] exp_busy(int k, int a);
        return (legal(k, a) && m_busy[k][a]) ? 8'h01 : 8'h00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[k][i]  = 8'h00;
                m_busy[k][i] = 1'b0;
            end
            m_rd1[k] = 8'h00;
            m_rd2[k] = 8'h00;
            m_rv[k]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rd_en) begin
                m_rd1[k] = val(k, int'(raddr1));
                m_rd2[k] = val(k, int'(raddr2));
                m_rv[k]  = 1'b1;
            end else begin
                m_rv[k] = 1'b0;
            end
            if (we && legal(k, int'(waddr))) begin
                m_reg[k][waddr]  = wdata;
                m_busy[k][waddr] = 1'b0;
            end
            if (rsv_en && legal(k, int'(rsv_addr))) m_busy[k][rsv_addr] = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("a_rdata1", a_rdata1, m_rd1[0]);
        chk("a_rdata2", a_rdata2, m_rd2[0]);
        chk("a_rvalid", {7'd0, a_rvalid}, {7'd0, m_rv[0]});
        chk("a_busy1", {7'd0, a_busy1}, exp_busy(0, int'(raddr1)));
        chk("a_busy2", {7'd0, a_busy2}, exp_busy(0, int'(raddr2)));
        chk("b_rdata1", b_rdata1, m_rd1[1]);
        chk("b_rdata2", b_rdata2, m_rd2[1]);
        chk("b_rvalid", {7'd0, b_rvalid}, {7'd0, m_rv[1]});
        chk("b_busy1", {7'd0, b_busy1}, exp_busy(1, int'(raddr1)));
        chk("b_busy2", {7'd0, b_busy2}, exp_busy(1, int'(raddr2)));
    endtask

    // One clock edge: advance the model on the inputs present, then compare after the edge.
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic re, input logic [2:0] r1, input logic [2:0] r2,
                         input logic w, input logic [2:0] wa, input logic [7:0] wd,
                         input logic rs, input logic [2:0] ra);
        rd_en = re; raddr1 = r1; raddr2 = r2;
        we = w; waddr = wa; wdata = wd; rsv_en = rs; rsv_addr = ra;
    endtask

    // Reset asserted between edges must clear outputs with no clock edge.
    task automatic mid_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        model_reset();
        #2;
        check_all();
        rst = 1'b1;

        // Write then read back
        drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0); cyc();
        drive(1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0); cyc();
        chk("wr_rd_a", a_rdata1, 8'hA5);
        chk("wr_rd_b", b_rdata1, 8'hA5);
        chk("wr_rd_valid", {7'd0, a_rvalid}, 8'h01);

        // Bypass vs. no bypass on a same-edge write/read
        drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd5, 8'h11, 1'b0, 3'd0); cyc();
        drive(1'b1, 3'd5, 3'd5, 1'b1, 3'd5, 8'h22, 1'b0, 3'd0); cyc();
        chk("byp_a1", a_rdata1, 8'h22);
        chk("byp_a2", a_rdata2, 8'h22);
        chk("nobyp_b1", b_rdata1, 8'h11);
        chk("nobyp_b2", b_rdata2, 8'h11);
        drive(1'b1, 3'd5, 3'd5, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0); cyc();
        chk("nobyp_b_next", b_rdata1, 8'h22);

        // Zero register ignores writes and reservations (dut_b only)
        drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 8'hFF, 1'b1, 3'd0); cyc();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0); cyc();
        chk("zero_b_data", b_rdata1, 8'h00);
        chk("zero_b_busy", {7'd0, b_busy1}, 8'h00);
        chk("nozero_a_data", a_rdata1, 8'hFF);
        chk("nozero_a_busy", {7'd0, a_busy1}, 8'h01);

        // Scoreboard: reserve, set-beats-clear, then clear
        drive(1'b0, 3'd2, 3'd4, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2); cyc();
        chk("sb_rsv", {7'd0, a_busy1}, 8'h01);
        drive(1'b0, 3'd2, 3'd4, 1'b1, 3'd2, 8'h5A, 1'b1, 3'd2); cyc();
        chk("sb_set_wins", {7'd0, b_busy1}, 8'h01);
        drive(1'b0, 3'd2, 3'd4, 1'b1, 3'd2, 8'h5B, 1'b0, 3'd0); cyc();
        chk("sb_clear", {7'd0, a_busy1}, 8'h00);

        // Out-of-range write/read on the 6-deep instance
        drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 8'h3C, 1'b1, 3'd6); cyc();
        drive(1'b1, 3'd7, 3'd6, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0); cyc();
        chk("oor_b", b_rdata1, 8'h00);
        chk("inrange_a", a_rdata1, 8'h3C);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'(i), 3'(5 - i), 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
            cyc();
        end

        // Asynchronous reset mid-operation with non-zero state
        mid_reset();
        chk("rst_a_data", a_rdata1, 8'h00);
        chk("rst_b_busy", {7'd0, b_busy1}, 8'h00);

        // Randomised traffic with occasional mid-cycle resets
        for (int n = 0; n < 2000; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) raddr1 = waddr;
            if ($urandom_range(0, 3) == 0) raddr2 = rsv_addr;
            if ($urandom_range(0, 5) == 0) rsv_addr = waddr;
            cyc();
            if ($urandom_range(0, 199) == 0) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
